uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver and upstream of its transmitter in PGM8755.
- Frames host byte stream into command packets: SYNC, CMD, ADDR_H, ADDR_L, LEN, DATA[LEN], CHK.
- Buffers payload, verifies XOR checksum, answers ACK/NAK through the UART transmitter, and presents validated commands to the programmer core via a valid/ready handshake.

---
 rtl/uart_cmd_parser.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Host command framer for the PGM8755 UART link: SYNC CMD ADDR_H ADDR_L LEN DATA[LEN] CHK.
// Buffers the payload, checks the XOR sum, answers ACK/NAK and hands good commands to the core.
module uart_cmd_parser #(
  parameter int unsigned CLK_RATE       = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned LEN_W          = 5,
  parameter int unsigned ADDR_W         = 11,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic [LEN_W-1:0]  buf_raddr,
  output logic [7:0]        buf_rdata,
  output logic              err_chk,
  output logic              err_timeout
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Elaboration guard: the length field must hold MAX_LEN and the clock must be real.
  if (LEN_W < $clog2(MAX_LEN + 1) || MAX_LEN > 255 || CLK_RATE == 0) begin : g_param_err
    $error("uart_cmd_parser: inconsistent parameters");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CHK, S_RESP, S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              good_q, good_d;
  logic [7:0]        addr_h_q, addr_h_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_q, new_tx_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic              err_chk_q, err_chk_d;
  logic              err_to_q, err_to_d;
  logic              buf_we_c;
  logic              parsing_c;
  logic [7:0]        buf_q [MAX_LEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      good_q      <= 1'b0;
      addr_h_q    <= '0;
      tx_data_q   <= '0;
      new_tx_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      good_q      <= good_d;
      addr_h_q    <= addr_h_d;
      tx_data_q   <= tx_data_d;
      new_tx_q    <= new_tx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
    end
  end

  // Payload store; contents are don't-care until written by a packet.
  always_ff @(posedge clk) begin
    if (buf_we_c) buf_q[idx_q[IDX_W-1:0]] <= rx_data;
  end

  assign parsing_c = (state_q inside {S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CHK});

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    good_d      = good_q;
    addr_h_d    = addr_h_q;
    tx_data_d   = tx_data_q;
    new_tx_d    = 1'b0;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    buf_we_c    = 1'b0;

    if (!parsing_c || new_rx_data) cnt_d = '0;
    else                           cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (new_rx_data && rx_data == SYNC_BYTE) begin
          state_d = S_CMD;
          acc_d   = '0;
          good_d  = 1'b0;
        end
      end
      S_CMD: begin
        if (new_rx_data) begin
          cmd_d   = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_ADDR_H;
        end
      end
      S_ADDR_H: begin
        if (new_rx_data) begin
          addr_h_d = rx_data;
          acc_d    = acc_q ^ rx_data;
          state_d  = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (new_rx_data) begin
          cmd_addr_d = ADDR_W'({addr_h_q, rx_data});
          acc_d      = acc_q ^ rx_data;
          state_d    = S_LEN;
        end
      end
      S_LEN: begin
        if (new_rx_data) begin
          cmd_len_d = LEN_W'(rx_data);
          acc_d     = acc_q ^ rx_data;
          if (rx_data > 8'(MAX_LEN)) begin
            err_chk_d = 1'b1;
            tx_data_d = NAK_BYTE;
            state_d   = S_RESP;
          end else if (rx_data == 8'h00) begin
            state_d = S_CHK;
          end else begin
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (new_rx_data) begin
          buf_we_c = 1'b1;
          acc_d    = acc_q ^ rx_data;
          idx_d    = idx_q + LEN_W'(1);
          if (idx_q + LEN_W'(1) == cmd_len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (new_rx_data) begin
          if (rx_data == acc_q) begin
            tx_data_d = ACK_BYTE;
            good_d    = 1'b1;
          end else begin
            tx_data_d = NAK_BYTE;
            err_chk_d = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!tx_busy) begin
          new_tx_d = 1'b1;
          if (good_q) begin
            cmd_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte silence abandons the packet; a byte in the same cycle takes priority.
    if (parsing_c && !new_rx_data && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      err_to_d = 1'b1;
      cnt_d    = '0;
      state_d  = S_IDLE;
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_to_q;
  assign buf_rdata   = (buf_raddr < LEN_W'(MAX_LEN)) ? buf_q[buf_raddr[IDX_W-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: packet table plus hand sequences for timeout, tx_busy and reset.
// Expected response bytes go into a queue as packets are sent and are popped on each tx pulse.
module tb_uart_cmd_parser;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned MAX_LEN = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              new_rx_data = 1'b0;
  logic              tx_busy = 1'b0;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [LEN_W-1:0]  buf_raddr = '0;
  logic [7:0]        buf_rdata;
  logic              err_chk;
  logic              err_timeout;

  uart_cmd_parser #(
    .CLK_RATE(50000000), .TIMEOUT_CYCLES(50000), .MAX_LEN(MAX_LEN),
    .LEN_W(LEN_W), .ADDR_W(ADDR_W),
    .SYNC_BYTE(8'h55), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .err_chk(err_chk), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        n;
    logic [191:0]      s;       // stream, first byte most significant
    logic [7:0]        resp;
    logic              good;
    logic              chk_err;
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int err_chk_cnt = 0;
  int to_cnt = 0;
  logic [7:0] exp_q [$];
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (new_tx_data) begin
        tx_cnt++;
        chk("tx_while_busy", 32'(tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %0h expected none", tx_data);
        end else begin
          chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (err_chk) err_chk_cnt++;
      if (err_timeout) to_cnt++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mkv(input int n, input logic [191:0] s, input logic [7:0] resp,
                               input logic good, input logic chk_err, input logic [7:0] c,
                               input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    vec_t v;
    v.n = 8'(n); v.s = s; v.resp = resp; v.good = good; v.chk_err = chk_err;
    v.cmd = c; v.addr = a; v.len = l;
    return v;
  endfunction

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    return v.s[8*(int'(v.n)-1-i) +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    new_rx_data = 1'b1;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) send_byte(vbyte(v, i));
  endtask

  task automatic wait_tx_done(input string name, input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: response missing after %0d cycles, expected %0h", name, max, exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic wait_valid_and_accept(input vec_t v);
    int k = 0;
    while (cmd_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_valid_rise", 32'(cmd_valid), 32'd1);
    chk("cmd", 32'(cmd), 32'(v.cmd));
    chk("cmd_addr", 32'(cmd_addr), 32'(v.addr));
    chk("cmd_len", 32'(cmd_len), 32'(v.len));
    for (int j = 0; j < int'(v.len); j++) begin
      buf_raddr = LEN_W'(j);
      #1;
      chk("buf_rdata", 32'(buf_rdata), 32'(vbyte(v, int'(v.n) - 1 - int'(v.len) + j)));
    end
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("valid_held_with_ready", 32'(cmd_valid), 32'd1);
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop_after_ready", 32'(cmd_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int ec0 = err_chk_cnt;
    int tc0 = tx_cnt;
    exp_q.push_back(v.resp);
    send_vec(v);
    wait_tx_done("resp", 30);
    if (v.good) begin
      wait_valid_and_accept(v);
    end else begin
      repeat (5) @(negedge clk);
      chk("no_cmd_valid", 32'(cmd_valid), 32'd0);
    end
    chk("err_chk_pulses", 32'(err_chk_cnt - ec0), 32'(v.chk_err));
    chk("tx_pulses", 32'(tx_cnt - tc0), 32'd1);
  endtask

  initial begin
    int tc0;
    int t0;
    int cyc;
    logic [7:0] x;
    vec_t mv;

    vecs[0] = mkv(8, 192'h5501_03FF_02A5_5A00, 8'h06, 1'b1, 1'b0, 8'h01, 11'h3FF, 5'd2);
    vecs[1] = mkv(8, 192'h5501_03FF_02A5_5A01, 8'h15, 1'b0, 1'b1, 8'h00, 11'h000, 5'd0);
    vecs[2] = mkv(8, 192'h00FF_5502_0010_0012, 8'h06, 1'b1, 1'b0, 8'h02, 11'h010, 5'd0);
    vecs[3] = mkv(5, 192'h55_0100_0011,        8'h15, 1'b0, 1'b1, 8'h00, 11'h000, 5'd0);
    vecs[4] = mkv(7, 192'h55_04FA_BC01_7734,   8'h06, 1'b1, 1'b0, 8'h04, 11'h2BC, 5'd1);

    repeat (3) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_new_tx", 32'(new_tx_data), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst_cmd_len", 32'(cmd_len), 32'd0);
    chk("rst_errs", 32'({err_chk, err_timeout}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Full-length payload at the MAX_LEN boundary.
    mv.s = '0;
    x = 8'h03 ^ 8'h07 ^ 8'hFF ^ 8'h10;
    mv.s = {mv.s[183:0], 8'h55};
    mv.s = {mv.s[183:0], 8'h03};
    mv.s = {mv.s[183:0], 8'h07};
    mv.s = {mv.s[183:0], 8'hFF};
    mv.s = {mv.s[183:0], 8'h10};
    for (int j = 0; j < 16; j++) begin
      mv.s = {mv.s[183:0], 8'(j * 37 + 5)};
      x = x ^ 8'(j * 37 + 5);
    end
    mv.s = {mv.s[183:0], x};
    mv = mkv(22, mv.s, 8'h06, 1'b1, 1'b0, 8'h03, 11'h7FF, 5'd16);
    run_vec(mv);
    chk("no_stray_timeout", 32'(to_cnt), 32'd0);

    // Inter-byte timeout, then a good packet.
    tc0 = tx_cnt;
    t0 = to_cnt;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h03);
    cyc = 0;
    while (to_cnt == t0 && cyc < 50100) begin
      @(posedge clk);
      cyc++;
    end
    chk("timeout_pulse", 32'(to_cnt - t0), 32'd1);
    chk("timeout_window", 32'(cyc >= 49990 && cyc <= 50010), 32'd1);
    repeat (5) @(negedge clk);
    chk("timeout_no_tx", 32'(tx_cnt - tc0), 32'd0);
    run_vec(vecs[0]);

    // Response held off by tx_busy.
    tx_busy = 1'b1;
    tc0 = tx_cnt;
    exp_q.push_back(8'h06);
    send_vec(vecs[0]);
    repeat (200) @(negedge clk);
    chk("busy_no_tx", 32'(tx_cnt - tc0), 32'd0);
    chk("busy_no_valid", 32'(cmd_valid), 32'd0);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    wait_tx_done("busy_resp", 10);
    repeat (3) @(negedge clk);
    chk("busy_one_pulse", 32'(tx_cnt - tc0), 32'd1);
    wait_valid_and_accept(vecs[0]);

    // Asynchronous reset after ADDR_H; the rest of the packet must be ignored.
    tc0 = tx_cnt;
    send_byte(8'h55); send_byte(8'h07); send_byte(8'h01);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_cmd", 32'(cmd), 32'd0);
    chk("arst_cmd_addr", 32'(cmd_addr), 32'd0);
    chk("arst_cmd_len", 32'(cmd_len), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_flags", 32'({new_tx_data, cmd_valid, err_chk, err_timeout}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_byte(8'hFF); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h00);
    repeat (30) @(negedge clk);
    chk("arst_no_tx", 32'(tx_cnt - tc0), 32'd0);
    chk("arst_no_valid", 32'(cmd_valid), 32'd0);

    run_vec(vecs[4]);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
